// File: rtl/io_input_wait_pkg.sv
// Shared definitions for the IO-read wait block: FSM encodings and read-data width.
package io_input_wait_pkg;

   localparam int IO_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/io_input_wait_btn_debounce.sv
// Enter-button conditioning: 2-FF synchroniser, stability counter, rising-edge pulse.
module io_input_wait_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic enter
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_q;
   logic             r_enter;
   logic [CNT_W-1:0] r_cnt;

   // Pulse is registered so raw-edge to enter latency is DEBOUNCE_CYCLES+3.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_q <= 1'b0;
         r_enter    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1    <= btn_raw;
         r_sync2    <= r_sync1;
         r_stable_q <= r_stable;
         r_enter    <= r_stable & ~r_stable_q;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign enter = r_enter;

endmodule

// File: rtl/io_input_wait.sv
// Holds an IO-read in MEM until a debounced enter press, then returns the latched switch value.
//  state   | meaning
//  IDLE    | no IO-read pending; stall request follows io_rd_req
//  WAIT    | IO-read stalled, waiting for a fresh enter press
//  DONE    | switch value captured; read data valid until the instruction advances
module io_input_wait
   import io_input_wait_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SW_WIDTH        = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_enter_raw,
   input  logic [SW_WIDTH-1:0]  sw,
   input  logic                 io_rd_req,
   input  logic                 stall,
   output logic                 enter,
   output logic                 stall_req_io,
   output logic [IO_DATA_W-1:0] io_rd_data,
   output logic                 io_rd_valid
);

   logic                 w_enter;
   logic                 w_capture;
   logic                 w_stall_req;
   logic                 w_valid;
   state_t               r_state;
   state_t               w_state_next;
   logic [IO_DATA_W-1:0] r_rd_data;

   io_input_wait_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_enter_raw),
      .enter   (w_enter)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_rd_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_capture) r_rd_data <= IO_DATA_W'(sw);
      end
   end

   // Outputs depend on state and io_rd_req only; stall is used solely for the DONE exit.
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_stall_req  = 1'b0;
      w_valid      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_stall_req = io_rd_req;
            if (io_rd_req) w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            w_stall_req = 1'b1;
            if (!io_rd_req) begin
               w_state_next = ST_IDLE;
            end else if (w_enter) begin
               w_capture    = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_valid = 1'b1;
            if (!stall) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign enter        = w_enter;
   assign stall_req_io = w_stall_req & ~rst;
   assign io_rd_valid  = w_valid;
   assign io_rd_data   = r_rd_data;

endmodule
